// File: rtl/counter_pkg.sv
// Shared definitions for the interval-timer controller: FSM state encoding and mode codes.
package counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage : counter_pkg

// File: rtl/tick_counter.sv
// WIDTH-bit up counter with synchronous clear (priority) and advance enable.
module tick_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Counter register: clear beats enable, wraps modulo 2**WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= {WIDTH{1'b0}};
    end else if (clr) begin
      r_q <= {WIDTH{1'b0}};
    end else if (en) begin
      r_q <= r_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule : tick_counter

// File: rtl/counter_ctrl.sv
// Interval timer sequencer: latches period/mode on start, drives the tick counter,
// detects terminal count and emits a registered one-cycle done pulse.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic             cnt_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_period;
  logic             r_mode;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_latch;
  logic             w_clr;
  logic             w_cnt_en;
  logic             w_terminal;
  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_term_val;

  // A stored period of 0 wraps to all-ones here, giving a 2**WIDTH interval
  assign w_term_val = r_period - {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_cnt_en   = (r_state == ST_RUN) && !hold;
  assign w_terminal = w_cnt_en && (w_count == w_term_val);

  // Next-state, counter clear and done decode; stop outranks terminal count
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_latch     = 1'b1;
          w_clr       = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_terminal) begin
          w_clr      = 1'b1;
          w_done_nxt = 1'b1;
          if (r_mode == MODE_PERIODIC) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_clr       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched configuration and done pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_period <= {WIDTH{1'b0}};
      r_mode   <= MODE_ONESHOT;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_latch) begin
        r_period <= period;
        r_mode   <= mode;
      end else begin
        r_period <= r_period;
        r_mode   <= r_mode;
      end
    end
  end

  tick_counter #(
    .WIDTH (WIDTH)
  ) u_tick_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .en    (w_cnt_en),
    .q     (w_count)
  );

  assign cnt_en = w_cnt_en;
  assign count  = w_count;
  assign busy   = (r_state == ST_RUN);
  assign done   = r_done;

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an interval-level model.
module tb_counter_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         hold;
  logic         mode;
  logic [W-1:0] period;
  logic         cnt_en;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int n_vec = 0;
  int n_err = 0;

  // Model state: running flag, enabled edges elapsed in this interval, interval length
  bit m_run  = 1'b0;
  bit m_mode = 1'b0;
  bit m_done = 1'b0;
  int m_k    = 0;
  int m_len  = 16;

  counter_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .stop   (stop),
    .hold   (hold),
    .mode   (mode),
    .period (period),
    .cnt_en (cnt_en),
    .count  (count),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an interval of L enabled edges, done after the L-th one
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run  = 1'b0;
        m_mode = 1'b0;
        m_done = 1'b0;
        m_k    = 0;
        m_len  = 16;
      end else begin
        m_done = 1'b0;
        if (!m_run) begin
          if (start && !stop) begin
            m_run  = 1'b1;
            m_mode = mode;
            m_len  = (period == 0) ? 16 : int'(period);
            m_k    = 0;
          end
        end else if (stop) begin
          m_run = 1'b0;
          m_k   = 0;
        end else if (!hold) begin
          if (m_k + 1 == m_len) begin
            m_k    = 0;
            m_done = 1'b1;
            if (!m_mode) m_run = 1'b0;
          end else begin
            m_k = m_k + 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_count",  int'(count),  m_k);
      check("cyc_busy",   int'(busy),   int'(m_run));
      check("cyc_done",   int'(done),   int'(m_done));
      check("cyc_cnt_en", int'(cnt_en), int'(m_run && !hold));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_op(input logic [W-1:0] p, input logic m);
    start  = 1'b1;
    period = p;
    mode   = m;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    int n;
    int ndone;
    int mx;

    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    hold   = 1'b0;
    mode   = 1'b0;
    period = '0;
    tick();
    tick();
    check("rst_count",  int'(count),  0);
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_cnt_en", int'(cnt_en), 0);
    rst_n = 1'b1;
    tick();

    // One-shot, period 5: count 1..4, then done with busy already low
    start_op(4'd5, 1'b0);
    check("os_start_busy", int'(busy), 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("os_count", int'(count), i);
      check("os_nodone", int'(done), 0);
    end
    tick();
    check("os_done", int'(done), 1);
    check("os_count_wrap", int'(count), 0);
    check("os_busy_fall", int'(busy), 0);
    tick();
    check("os_done_pulse", int'(done), 0);

    // Periodic, period 3: four pulses in twelve cycles, then stop
    start_op(4'd3, 1'b1);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      ndone += int'(done);
    end
    check("per_pulses", ndone, 4);
    check("per_busy", int'(busy), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("per_stop_busy", int'(busy), 0);
    check("per_stop_count", int'(count), 0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      ndone += int'(done);
    end
    check("per_after_stop", ndone, 0);

    // Hold for 4 cycles at count 2 stretches a 6-cycle one-shot to 10
    start_op(4'd6, 1'b0);
    tick();
    tick();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("hold_count", int'(count), 2);
    check("hold_busy", int'(busy), 1);
    hold = 1'b0;
    n = 6;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    check("hold_latency", n, 10);

    // Period 0 means a full 16-cycle interval reaching 0xF
    start_op(4'd0, 1'b0);
    n  = 0;
    mx = 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (int'(count) > mx) mx = int'(count);
    end
    check("p0_latency", n, 16);
    check("p0_max_count", mx, 15);
    tick();

    // Period 1 periodic: done every cycle, count pinned at 0
    start_op(4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("p1_done", int'(done), 1);
      check("p1_count", int'(count), 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Stop on the terminal cycle suppresses done
    start_op(4'd3, 1'b0);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_term_done", int'(done), 0);
    check("stop_term_busy", int'(busy), 0);

    // Start while busy is ignored: interval, period and mode unchanged
    start_op(4'd4, 1'b0);
    tick();
    start  = 1'b1;
    period = 4'd9;
    mode   = 1'b1;
    tick();
    start  = 1'b0;
    n = 2;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    check("busy_start_latency", n, 4);
    check("busy_start_oneshot", int'(busy), 0);
    tick();

    // Start together with stop in IDLE stays IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_idle", int'(busy), 0);
    tick();
    check("start_stop_idle2", int'(busy), 0);

    // Asynchronous reset mid-interval clears outputs without a clock edge
    start_op(4'd8, 1'b0);
    tick();
    tick();
    tick();
    check("arst_pre_count", int'(count), 3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_count",  int'(count),  0);
    check("arst_busy",   int'(busy),   0);
    check("arst_done",   int'(done),   0);
    check("arst_cnt_en", int'(cnt_en), 0);
    #2 rst_n = 1'b1;
    tick();

    // Randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      stop   = ($urandom_range(0, 15) == 0);
      hold   = ($urandom_range(0, 4) == 0);
      mode   = 1'($urandom_range(0, 1));
      period = W'($urandom_range(0, 15));
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
    hold  = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_counter_ctrl
